inst_rom_loader: RTL and testbench

- Write-side counterpart of the instruction memory: receives a byte-serial program image and writes it into instruction RAM as 16-bit little-endian halfwords.
- Holds the CPU off instruction fetch while loading, so fetch sees chip-disable.
- Sits between the boot/UART byte source and the instruction memory write port.
- Image format:
  - Length header N: 2 bytes, little-endian, counted in halfwords.
  - 2N data bytes, low byte first.
  - 1 checksum byte: XOR of all data bytes.

---
 rtl/inst_rom_loader_if.sv | 28 ++
 rtl/inst_rom_loader.sv | 133 +++++++++++++
 tb/tb_inst_rom_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_rom_loader_if.sv
// Signal bundle between the boot byte source, the program loader and the
// instruction memory write port.
interface inst_rom_loader_if #(
    parameter int WORD_ADDR_W = 10
);
    // Byte stream: a byte moves on a rising edge where in_valid && in_ready.
    // in_ready depends only on loader state, never on in_valid.
    logic                   start;
    logic                   in_valid;
    logic [7:0]             in_data;
    logic                   in_ready;
    logic                   mem_we;
    logic [WORD_ADDR_W-1:0] mem_addr;
    logic [15:0]            mem_wdata;
    logic                   busy;
    logic                   done;
    logic                   err;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err
    );
endinterface

// File: rtl/inst_rom_loader.sv
// Receives a byte-serial program image (length, little-endian halfwords,
// XOR checksum) and writes it into instruction RAM while holding fetch off.
module inst_rom_loader #(
    parameter int WORD_ADDR_W = 10,
    parameter int LEN_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_rom_loader_if.slave      bus,
    output logic [2:0]            fsm_state
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DAT_LO = 3'd3,
        S_DAT_HI = 3'd4,
        S_CHK    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [LEN_W:0] CAPACITY = {{LEN_W{1'b0}}, 1'b1} << WORD_ADDR_W;

    state_t                 state, state_nxt;
    logic [LEN_W-1:0]       len_q;
    logic [7:0]             chk_q;
    logic [7:0]             lo_q;
    logic [WORD_ADDR_W:0]   cnt_q;
    logic                   mem_we_q;
    logic [WORD_ADDR_W-1:0] mem_addr_q;
    logic [15:0]            mem_wdata_q;
    logic                   err_q;

    logic                   receiving;
    logic                   accept;
    logic [LEN_W-1:0]       full_len;
    logic                   oversize;
    logic [WORD_ADDR_W:0]   cnt_inc;
    logic                   last_word;

    assign receiving = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_DAT_LO) || (state == S_DAT_HI) ||
                       (state == S_CHK);
    assign accept    = bus.in_valid && receiving;
    // Length as it will be once the high byte currently on in_data is taken.
    assign full_len  = {bus.in_data, len_q[7:0]};
    assign oversize  = {1'b0, full_len} > CAPACITY;
    assign cnt_inc   = cnt_q + 1'b1;
    assign last_word = {{(LEN_W-WORD_ADDR_W-1){1'b0}}, cnt_inc} == len_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_LEN_LO;
            S_LEN_LO: if (accept) state_nxt = S_LEN_HI;
            S_LEN_HI: begin
                if (accept) begin
                    if (full_len == '0 || oversize) state_nxt = S_DONE;
                    else                            state_nxt = S_DAT_LO;
                end
            end
            S_DAT_LO: if (accept) state_nxt = S_DAT_HI;
            S_DAT_HI: if (accept) state_nxt = last_word ? S_CHK : S_DAT_LO;
            S_CHK:    if (accept) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q       <= '0;
            chk_q       <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        err_q <= 1'b0;
                        chk_q <= '0;
                        cnt_q <= '0;
                        len_q <= '0;
                    end
                end
                S_LEN_LO: if (accept) len_q[7:0] <= bus.in_data;
                S_LEN_HI: begin
                    if (accept) begin
                        len_q[15:8] <= bus.in_data;
                        if (oversize) err_q <= 1'b1;
                    end
                end
                S_DAT_LO: begin
                    if (accept) begin
                        lo_q  <= bus.in_data;
                        chk_q <= chk_q ^ bus.in_data;
                    end
                end
                // Write issues on the high-byte edge, so one write per two bytes.
                S_DAT_HI: begin
                    if (accept) begin
                        chk_q       <= chk_q ^ bus.in_data;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= cnt_q[WORD_ADDR_W-1:0];
                        mem_wdata_q <= {bus.in_data, lo_q};
                        cnt_q       <= cnt_inc;
                    end
                end
                S_CHK: if (accept) err_q <= (bus.in_data != chk_q);
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = receiving;
    assign bus.busy      = receiving;
    assign bus.done      = (state == S_DONE);
    assign bus.err       = err_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign fsm_state     = state;
endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: image loads, checksum/length errors,
// full-capacity load, asynchronous reset and ignored start pulses.
module tb_inst_rom_loader;
    logic       clk;
    logic       rst;
    logic [2:0] fsm_state;
    int         checks;
    int         failures;

    logic [9:0]  obs_addr_q[$];
    logic [15:0] obs_data_q[$];
    logic [15:0] exp_q[$];

    inst_rom_loader_if #(.WORD_ADDR_W(10)) io ();

    inst_rom_loader #(.WORD_ADDR_W(10), .LEN_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (io),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (io.mem_we === 1'b1) begin
            obs_addr_q.push_back(io.mem_addr);
            obs_data_q.push_back(io.mem_wdata);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        io.in_valid = 1'b1;
        io.in_data  = b;
        for (int t = 0; t < 50; t++) begin
            if (io.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                io.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        io.in_valid = 1'b0;
        checks++;
        failures++;
        $display("FAIL send_byte_timeout: byte %02h in_ready never 1 (required 1)", b);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
    endtask

    task automatic clear_obs();
        obs_addr_q.delete();
        obs_data_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        io.start = 1'b0;
        io.in_valid = 1'b0;
        io.in_data = 8'h00;
        #12;
        checks++;
        if ({io.busy, io.done, io.err, io.in_ready, io.mem_we} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b required 00000",
                     {io.busy, io.done, io.err, io.in_ready, io.mem_we});
        end
        checks++;
        if ({io.mem_addr, io.mem_wdata} !== 26'h0) begin
            failures++;
            $display("FAIL reset_bus: addr %h data %h required 0 0", io.mem_addr, io.mem_wdata);
        end
        checks++;
        if (fsm_state !== 3'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d required 0", fsm_state);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_load();
        clear_obs();
        pulse_start();
        checks++;
        if (io.busy !== 1'b1 || fsm_state !== 3'd1) begin
            failures++;
            $display("FAIL basic_busy_after_start: busy %b state %0d required 1 1", io.busy, fsm_state);
        end
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h34, 0); send_byte(8'h12, 0);
        send_byte(8'h78, 0); send_byte(8'h56, 0);
        @(negedge clk);
        checks++;
        if (io.busy !== 1'b1 || fsm_state !== 3'd5) begin
            failures++;
            $display("FAIL basic_busy_before_chk: busy %b state %0d required 1 5", io.busy, fsm_state);
        end
        send_byte(8'h08, 0);
        @(negedge clk);
        checks++;
        if (io.done !== 1'b1 || io.err !== 1'b0 || io.busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done: done %b err %b busy %b required 1 0 0", io.done, io.err, io.busy);
        end
        @(negedge clk);
        checks++;
        if (io.done !== 1'b0 || fsm_state !== 3'd0) begin
            failures++;
            $display("FAIL basic_done_pulse: done %b state %0d required 0 0", io.done, fsm_state);
        end
        checks++;
        if (obs_addr_q.size() != 2) begin
            failures++;
            $display("FAIL basic_write_count: got %0d required 2", obs_addr_q.size());
        end else if (obs_addr_q[0] !== 10'd0 || obs_data_q[0] !== 16'h1234 ||
                     obs_addr_q[1] !== 10'd1 || obs_data_q[1] !== 16'h5678) begin
            failures++;
            $display("FAIL basic_writes: got %h=%h %h=%h required 000=1234 001=5678",
                     obs_addr_q[0], obs_data_q[0], obs_addr_q[1], obs_data_q[1]);
        end
    endtask

    task automatic test_bad_chk_then_zero_len();
        clear_obs();
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h34, 1); send_byte(8'h12, 0);
        send_byte(8'h78, 2); send_byte(8'h56, 0);
        send_byte(8'hF7, 0);
        @(negedge clk);
        checks++;
        if (io.done !== 1'b1 || io.err !== 1'b1) begin
            failures++;
            $display("FAIL badchk_done: done %b err %b required 1 1", io.done, io.err);
        end
        checks++;
        if (obs_addr_q.size() != 2) begin
            failures++;
            $display("FAIL badchk_write_count: got %0d required 2", obs_addr_q.size());
        end
        repeat (4) @(negedge clk);
        checks++;
        if (io.err !== 1'b1) begin
            failures++;
            $display("FAIL badchk_err_sticky: got %b required 1", io.err);
        end
        pulse_start();
        checks++;
        if (io.err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear_on_start: got %b required 0", io.err);
        end
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        checks++;
        if (io.done !== 1'b1 || io.err !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_done: done %b err %b required 1 0", io.done, io.err);
        end
        checks++;
        if (obs_addr_q.size() != 2) begin
            failures++;
            $display("FAIL zero_len_no_write: writes %0d required 2", obs_addr_q.size());
        end
    endtask

    task automatic test_oversize();
        clear_obs();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        @(negedge clk);
        checks++;
        if (io.done !== 1'b1 || io.err !== 1'b1 || io.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL oversize_done: done %b err %b in_ready %b required 1 1 0",
                     io.done, io.err, io.in_ready);
        end
        io.in_valid = 1'b1;
        io.in_data  = 8'hAA;
        repeat (3) @(negedge clk);
        checks++;
        if (io.in_ready !== 1'b0 || fsm_state !== 3'd0 || io.err !== 1'b1) begin
            failures++;
            $display("FAIL oversize_idle: in_ready %b state %0d err %b required 0 0 1",
                     io.in_ready, fsm_state, io.err);
        end
        io.in_valid = 1'b0;
        checks++;
        if (obs_addr_q.size() != 0) begin
            failures++;
            $display("FAIL oversize_no_write: got %0d required 0", obs_addr_q.size());
        end
    endtask

    task automatic test_full_capacity();
        logic [7:0] chk;
        int         bad;
        clear_obs();
        exp_q.delete();
        chk = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            exp_q.push_back(16'($urandom_range(0, 65535)));
            chk = chk ^ exp_q[i][7:0] ^ exp_q[i][15:8];
        end
        pulse_start();
        send_byte(8'h00, $urandom_range(0, 1));
        send_byte(8'h04, $urandom_range(0, 1));
        for (int i = 0; i < 1024; i++) begin
            send_byte(exp_q[i][7:0], $urandom_range(0, 1));
            send_byte(exp_q[i][15:8], $urandom_range(0, 1));
        end
        send_byte(chk, $urandom_range(0, 1));
        @(negedge clk);
        checks++;
        if (io.done !== 1'b1 || io.err !== 1'b0) begin
            failures++;
            $display("FAIL full_done: done %b err %b required 1 0", io.done, io.err);
        end
        checks++;
        if (obs_addr_q.size() != 1024) begin
            failures++;
            $display("FAIL full_write_count: got %0d required 1024", obs_addr_q.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 1024; i++) begin
                if (obs_addr_q[i] !== 10'(i) || obs_data_q[i] !== exp_q[i]) begin
                    if (bad == 0)
                        $display("FAIL full_write_%0d: got %h=%h required %h=%h",
                                 i, obs_addr_q[i], obs_data_q[i], 10'(i), exp_q[i]);
                    bad++;
                end
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL full_data: %0d bad writes, required 0", bad);
            end
            checks++;
            if (obs_addr_q[1023] !== 10'h3FF) begin
                failures++;
                $display("FAIL full_last_addr: got %h required 3ff", obs_addr_q[1023]);
            end
        end
    endtask

    task automatic test_async_reset();
        clear_obs();
        pulse_start();
        send_byte(8'h05, 0); send_byte(8'h00, 0);
        send_byte(8'h01, 0); send_byte(8'h02, 0);
        send_byte(8'h03, 0); send_byte(8'h04, 0);
        send_byte(8'h05, 0); send_byte(8'h06, 0);
        checks++;
        if (io.mem_we !== 1'b1 || io.mem_addr !== 10'd2 || io.mem_wdata !== 16'h0605) begin
            failures++;
            $display("FAIL areset_pre_write: we %b addr %h data %h required 1 002 0605",
                     io.mem_we, io.mem_addr, io.mem_wdata);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (io.busy !== 1'b0 || io.mem_we !== 1'b0 || io.in_ready !== 1'b0 || fsm_state !== 3'd0) begin
            failures++;
            $display("FAIL areset_drop: busy %b we %b in_ready %b state %0d required 0 0 0 0",
                     io.busy, io.mem_we, io.in_ready, fsm_state);
        end
        @(negedge clk);
        rst = 1'b1;
        clear_obs();
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'hCD, 0); send_byte(8'hAB, 0);
        send_byte(8'h66, 0);
        @(negedge clk);
        checks++;
        if (io.done !== 1'b1 || io.err !== 1'b0) begin
            failures++;
            $display("FAIL areset_reload_done: done %b err %b required 1 0", io.done, io.err);
        end
        checks++;
        if (obs_addr_q.size() != 1) begin
            failures++;
            $display("FAIL areset_reload_count: got %0d required 1", obs_addr_q.size());
        end else if (obs_addr_q[0] !== 10'd0 || obs_data_q[0] !== 16'hABCD) begin
            failures++;
            $display("FAIL areset_reload_write: got %h=%h required 000=abcd", obs_addr_q[0], obs_data_q[0]);
        end
    endtask

    task automatic test_start_ignored();
        clear_obs();
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        pulse_start();
        checks++;
        if (fsm_state !== 3'd3) begin
            failures++;
            $display("FAIL start_in_dat_lo: state %0d required 3", fsm_state);
        end
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        send_byte(8'h33, 0); send_byte(8'h44, 0);
        send_byte(8'h44, 0);
        io.start = 1'b1;
        @(negedge clk);
        checks++;
        if (io.done !== 1'b1 || io.err !== 1'b0) begin
            failures++;
            $display("FAIL start_at_done_pulse: done %b err %b required 1 0", io.done, io.err);
        end
        @(posedge clk);
        #1;
        io.start = 1'b0;
        checks++;
        if (fsm_state !== 3'd0) begin
            failures++;
            $display("FAIL start_at_done_ignored: state %0d required 0", fsm_state);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (fsm_state !== 3'd0 || io.busy !== 1'b0) begin
            failures++;
            $display("FAIL start_ignored_idle: state %0d busy %b required 0 0", fsm_state, io.busy);
        end
        checks++;
        if (obs_addr_q.size() != 2) begin
            failures++;
            $display("FAIL start_ignored_count: got %0d required 2", obs_addr_q.size());
        end else if (obs_addr_q[0] !== 10'd0 || obs_data_q[0] !== 16'h2211 ||
                     obs_addr_q[1] !== 10'd1 || obs_data_q[1] !== 16'h4433) begin
            failures++;
            $display("FAIL start_ignored_writes: got %h=%h %h=%h required 000=2211 001=4433",
                     obs_addr_q[0], obs_data_q[0], obs_addr_q[1], obs_data_q[1]);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic_load();
        test_bad_chk_then_zero_len();
        test_oversize();
        test_full_capacity();
        test_async_reset();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
